// File: rtl/rv64g_launch_scoreboard.sv
// ============================================================================
// Module      : rv64g_launch_scoreboard
// Description : Register-lock scoreboard that gates instruction launch on RAW/WAW
//               hazards, in-flight count and blocking instructions.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module rv64g_launch_scoreboard #(
  parameter int NUM_REGS        = 64,
  parameter int NUM_OUTSTANDING = 7,
  parameter int NUM_WB          = 2,
  parameter int DW              = 64
) (
  input  logic                                 clk_i,
  input  logic                                 arst_i,
  input  logic [DW-1:0]                        instr_i,
  input  logic [NUM_REGS-1:0]                  instr_reg_req_i,
  input  logic [$clog2(NUM_REGS)-1:0]          instr_rd_i,
  input  logic                                 instr_blocking_i,
  input  logic                                 instr_valid_i,
  output logic                                 instr_ready_o,
  output logic [DW-1:0]                        instr_o,
  output logic                                 instr_valid_o,
  input  logic                                 instr_ready_i,
  input  logic [NUM_WB-1:0]                    wb_valid_i,
  input  logic [NUM_WB*$clog2(NUM_REGS)-1:0]   wb_rd_i,
  output logic [$clog2(NUM_OUTSTANDING+1)-1:0] outstanding_o,
  output logic [NUM_REGS-1:0]                  locks_o
);

  localparam int RW = $clog2(NUM_REGS);
  localparam int CW = $clog2(NUM_OUTSTANDING + 1);
  localparam int PW = $clog2(NUM_WB + 1);

  // x0 is hard-wired, so it can never participate in a hazard
  localparam logic [NUM_REGS-1:0] c_X0_MASK = {{(NUM_REGS-1){1'b1}}, 1'b0};

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_BLOCK = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [NUM_REGS-1:0] r_locks;
  logic [CW-1:0]       r_outstanding;
  logic [DW-1:0]       r_instr;
  logic                r_valid;

  logic [NUM_REGS-1:0] w_wb_clr;
  logic [PW-1:0]       w_wb_cnt;
  logic [NUM_REGS-1:0] w_locks_eff;
  logic [NUM_REGS-1:0] w_set;
  logic                w_hazard;
  logic                w_cnt_ok;
  logic                w_out_free;
  logic                w_idle;
  logic                w_blk_ok;
  logic                w_ready;
  logic                w_launch;
  logic [CW:0]         w_cnt_inc;
  logic [CW:0]         w_pop_ext;
  logic [CW-1:0]       w_cnt_nxt;

  always_comb begin
    w_wb_clr = '0;
    w_wb_cnt = '0;
    for (int k = 0; k < NUM_WB; k++) begin
      if (wb_valid_i[k]) begin
        w_wb_clr[wb_rd_i[k*RW +: RW]] = 1'b1;
        w_wb_cnt = w_wb_cnt + PW'(1);
      end
    end
  end

  // Same-cycle writebacks release their registers before the hazard test
  assign w_locks_eff = r_locks & ~w_wb_clr;
  assign w_hazard    = |(instr_reg_req_i & w_locks_eff & c_X0_MASK);
  assign w_cnt_ok    = (32'(r_outstanding) < (32'(NUM_OUTSTANDING) + 32'(w_wb_cnt)));
  assign w_out_free  = !r_valid || instr_ready_i;
  assign w_idle      = (r_outstanding == '0) && !r_valid;
  assign w_blk_ok    = !instr_blocking_i || w_idle;

  assign w_ready  = !arst_i && (r_state == ST_RUN) && !w_hazard &&
                    w_cnt_ok && w_out_free && w_blk_ok;
  assign w_launch = instr_valid_i && w_ready;

  always_comb begin
    w_set = '0;
    if (w_launch && (instr_rd_i != '0)) begin
      w_set[instr_rd_i] = 1'b1;
    end
  end

  assign w_cnt_inc = {1'b0, r_outstanding} + {{CW{1'b0}}, w_launch};
  assign w_pop_ext = (CW+1)'(w_wb_cnt);
  assign w_cnt_nxt = (w_cnt_inc > w_pop_ext) ? CW'(w_cnt_inc - w_pop_ext) : '0;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_launch && instr_blocking_i) begin
          w_state_nxt = ST_BLOCK;
        end
      end
      ST_BLOCK: begin
        if (w_idle) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Launch set wins over a same-cycle writeback clear of the same register
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_locks       <= '0;
      r_outstanding <= '0;
      r_instr       <= '0;
      r_valid       <= 1'b0;
    end else begin
      r_locks       <= w_locks_eff | w_set;
      r_outstanding <= w_cnt_nxt;
      if (w_launch) begin
        r_instr <= instr_i;
        r_valid <= 1'b1;
      end else if (instr_ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign instr_ready_o = w_ready;
  assign instr_o       = r_instr;
  assign instr_valid_o = r_valid;
  assign outstanding_o = r_outstanding;
  assign locks_o       = r_locks;

endmodule

`default_nettype wire

// File: tb/tb_rv64g_launch_scoreboard.sv
// ============================================================================
// Module      : tb_rv64g_launch_scoreboard
// Description : Directed and random checks of the launch scoreboard against a
//               cycle-level behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_rv64g_launch_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        arst;
  logic [63:0] instr;
  logic [63:0] req;
  logic [5:0]  rd;
  logic        blk;
  logic        vin;
  logic        rdy_in;
  logic [1:0]  wbv;
  logic [5:0]  wbrd0;
  logic [5:0]  wbrd1;
  logic        rdy_o;
  logic [63:0] instr_o;
  logic        vout;
  logic [2:0]  cnt_o;
  logic [63:0] locks_o;

  rv64g_launch_scoreboard dut (
    .clk_i            (clk),
    .arst_i           (arst),
    .instr_i          (instr),
    .instr_reg_req_i  (req),
    .instr_rd_i       (rd),
    .instr_blocking_i (blk),
    .instr_valid_i    (vin),
    .instr_ready_o    (rdy_o),
    .instr_o          (instr_o),
    .instr_valid_o    (vout),
    .instr_ready_i    (rdy_in),
    .wb_valid_i       (wbv),
    .wb_rd_i          ({wbrd1, wbrd0}),
    .outstanding_o    (cnt_o),
    .locks_o          (locks_o)
  );

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  bit [63:0]   m_locks;
  int          m_cnt;
  bit          m_ov;
  logic [63:0] m_out;
  bit          m_blocked;
  int          pend[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    vin = 1'b0; blk = 1'b0; req = '0; rd = '0; instr = '0;
    rdy_in = 1'b1; wbv = '0; wbrd0 = '0; wbrd1 = '0;
  endtask

  task automatic issue(input logic [63:0] i, input int r, input logic [63:0] rq, input bit b);
    instr = i; rd = 6'(r); req = rq; blk = b; vin = 1'b1;
  endtask

  task automatic model_reset();
    m_locks = '0; m_cnt = 0; m_ov = 1'b0; m_out = '0; m_blocked = 1'b0;
    pend.delete();
  endtask

  // Compare every output against the model, then advance the model one clock
  task automatic step();
    bit [63:0] clr;
    int        pop;
    bit        hz;
    bit        exp_rdy;
    bit        launch;
    int        after;
    bit        idle_now;
    #1;
    clr = '0;
    pop = 0;
    if (wbv[0]) begin clr[wbrd0] = 1'b1; pop++; end
    if (wbv[1]) begin clr[wbrd1] = 1'b1; pop++; end
    hz = 1'b0;
    for (int i = 1; i < 64; i++) begin
      if (req[i] && m_locks[i] && !clr[i]) hz = 1'b1;
    end
    after    = (m_cnt > pop) ? m_cnt - pop : 0;
    idle_now = (m_cnt == 0) && !m_ov;
    exp_rdy  = !m_blocked && !hz && (after < 7) && (!m_ov || rdy_in) && (!blk || idle_now);
    chk("ready", 64'(rdy_o), 64'(exp_rdy));
    chk("valid_o", 64'(vout), 64'(m_ov));
    chk("instr_o", instr_o, m_out);
    chk("locks_o", locks_o, m_locks);
    chk("outstanding_o", 64'(cnt_o), 64'(m_cnt));
    launch = vin && exp_rdy;
    @(posedge clk);
    m_locks = m_locks & ~clr;
    if (launch && rd != 0) m_locks[rd] = 1'b1;
    m_cnt = m_cnt + (launch ? 1 : 0) - pop;
    if (m_cnt < 0) m_cnt = 0;
    if (!m_blocked && launch && blk) m_blocked = 1'b1;
    else if (m_blocked && idle_now) m_blocked = 1'b0;
    if (launch) begin
      m_ov  = 1'b1;
      m_out = instr;
      pend.push_back(int'(rd));
    end else if (m_ov && rdy_in) begin
      m_ov = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2 arst = 1'b1;
    #1;
    chk("rst_locks", locks_o, 64'h0);
    chk("rst_outstanding", 64'(cnt_o), 64'h0);
    chk("rst_valid", 64'(vout), 64'h0);
    chk("rst_instr", instr_o, 64'h0);
    chk("rst_ready", 64'(rdy_o), 64'h0);
    idle();
    @(posedge clk);
    @(negedge clk);
    arst = 1'b0;
    model_reset();
  endtask

  initial begin
    int idx;
    arst = 1'b1;
    idle();
    model_reset();
    @(negedge clk);
    do_reset();

    // Single launch held by downstream backpressure
    rdy_in = 1'b0;
    issue(64'hA5A5_0001_DEAD_BEEF, 5, 64'h20, 1'b0);
    step();
    vin = 1'b0;
    repeat (3) begin
      step();
      chk("s1_valid", 64'(vout), 64'h1);
      chk("s1_instr", instr_o, 64'hA5A5_0001_DEAD_BEEF);
    end
    chk("s1_lock5", 64'(locks_o[5]), 64'h1);
    chk("s1_cnt", 64'(cnt_o), 64'h1);
    rdy_in = 1'b1;
    step();
    chk("s1_drained", 64'(vout), 64'h0);

    // RAW hazard released by a same-cycle writeback
    issue(64'hB0B0_0002_0000_0005, 5, 64'h20, 1'b0);
    #1 chk("s2_stall", 64'(rdy_o), 64'h0);
    step();
    step();
    wbv = 2'b01; wbrd0 = 6'd5;
    #1 chk("s2_wb_ready", 64'(rdy_o), 64'h1);
    step();
    idle();
    chk("s2_lock_set", 64'(locks_o[5]), 64'h1);
    chk("s2_cnt", 64'(cnt_o), 64'h1);
    chk("s2_instr", instr_o, 64'hB0B0_0002_0000_0005);

    // Fill to the in-flight limit
    do_reset();
    for (int i = 0; i < 7; i++) begin
      issue(64'(i + 100), 10 + i, 64'h1 << (10 + i), 1'b0);
      step();
    end
    chk("s3_cnt7", 64'(cnt_o), 64'h7);
    issue(64'hC0C0, 20, 64'h1 << 20, 1'b0);
    #1 chk("s3_full", 64'(rdy_o), 64'h0);
    step();
    wbv = 2'b01; wbrd0 = 6'd10;
    #1 chk("s3_wb_ready", 64'(rdy_o), 64'h1);
    step();
    idle();
    chk("s3_cnt_after", 64'(cnt_o), 64'h7);

    // Blocking instruction
    do_reset();
    issue(64'hD001, 1, 64'h2, 1'b0);
    step();
    issue(64'hD002, 2, 64'h4, 1'b0);
    step();
    chk("s4_cnt2", 64'(cnt_o), 64'h2);
    issue(64'hD003, 3, 64'h8, 1'b1);
    #1 chk("s4_blk_wait", 64'(rdy_o), 64'h0);
    wbv = 2'b01; wbrd0 = 6'd1;
    step();
    wbv = 2'b10; wbrd0 = 6'd0; wbrd1 = 6'd2;
    step();
    wbv = 2'b00; wbrd1 = 6'd0;
    #1 chk("s4_blk_go", 64'(rdy_o), 64'h1);
    step();
    issue(64'hD004, 4, 64'h10, 1'b0);
    #1 chk("s4_in_block", 64'(rdy_o), 64'h0);
    wbv = 2'b01; wbrd0 = 6'd3;
    step();
    wbv = 2'b00; wbrd0 = 6'd0;
    #1 chk("s4_block_exit", 64'(rdy_o), 64'h0);
    step();
    #1 chk("s4_run", 64'(rdy_o), 64'h1);
    step();
    idle();
    chk("s4_lock4", 64'(locks_o[4]), 64'h1);

    // Dual writeback to one register; rd=0 launch
    do_reset();
    issue(64'hE001, 3, 64'h8, 1'b0);
    step();
    issue(64'hE002, 3, 64'h0, 1'b0);
    step();
    idle();
    chk("s5_cnt2", 64'(cnt_o), 64'h2);
    wbv = 2'b11; wbrd0 = 6'd3; wbrd1 = 6'd3;
    step();
    idle();
    chk("s5_locks_clr", locks_o, 64'h0);
    chk("s5_cnt0", 64'(cnt_o), 64'h0);
    issue(64'hE003, 0, 64'h1, 1'b0);
    step();
    idle();
    chk("s5_x0_nolock", locks_o, 64'h0);
    chk("s5_x0_cnt", 64'(cnt_o), 64'h1);
    wbv = 2'b01; wbrd0 = 6'd0;
    step();
    idle();
    chk("s5_x0_wb", 64'(cnt_o), 64'h0);

    // Reset mid-operation
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      issue(64'(i), i, 64'h1 << i, 1'b0);
      step();
    end
    idle();
    chk("s6_cnt4", 64'(cnt_o), 64'h4);
    chk("s6_locks", locks_o, 64'h1E);
    do_reset();
    #1 chk("s6_first_ready", 64'(rdy_o), 64'h1);
    step();

    // Random traffic with writebacks drawn from the in-flight set
    do_reset();
    repeat (400) begin
      instr  = {$urandom, $urandom};
      rd     = 6'($urandom_range(0, 7));
      req    = '0;
      if (rd != 0) req[rd] = 1'b1;
      if ($urandom_range(0, 2) == 0) req[$urandom_range(0, 7)] = 1'b1;
      blk    = ($urandom_range(0, 9) == 0);
      vin    = ($urandom_range(0, 9) < 7);
      rdy_in = ($urandom_range(0, 3) != 0);
      wbv = '0; wbrd0 = '0; wbrd1 = '0;
      if (pend.size() > 0 && $urandom_range(0, 2) == 0) begin
        idx = int'($urandom_range(0, pend.size() - 1));
        wbrd0 = 6'(pend[idx]);
        wbv[0] = 1'b1;
        pend.delete(idx);
      end
      if (pend.size() > 0 && $urandom_range(0, 2) == 0) begin
        idx = int'($urandom_range(0, pend.size() - 1));
        wbrd1 = 6'(pend[idx]);
        wbv[1] = 1'b1;
        pend.delete(idx);
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
